// File: rtl/store_merge_if.sv
// ============================================================================
// Module  : store_merge_if
// Purpose : Request, memory-port and status bundle of the store-size unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_merge_if;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_data_out;
  logic        busy;
  logic        done;
  logic        misaligned;

  // master: control unit plus memory read return; slave: the store unit
  modport master (
    output start, size, addr, store_data, mem_data_in,
    input  mem_addr, mem_wr, mem_data_out, busy, done, misaligned
  );

  modport slave (
    input  start, size, addr, store_data, mem_data_in,
    output mem_addr, mem_wr, mem_data_out, busy, done, misaligned
  );
endinterface

`default_nettype wire

// File: rtl/store_merge_ctrl.sv
// ============================================================================
// Module  : store_merge_ctrl
// Purpose : Word/half/byte store unit; sub-word stores use read-modify-write.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_merge_ctrl #(
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  store_merge_if.slave bus
);

  localparam logic [1:0] c_SIZE_WORD = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_BYTE = 2'b10;
  localparam logic [2:0] c_LAST_READ = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_data;
  logic [31:0] r_read_word;
  logic [2:0]  r_cnt;
  logic        w_accept;
  logic        w_misaligned;
  logic        w_is_word;
  logic        w_last_read;
  logic [31:0] w_merged;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_last_read = (r_state == S_READ) && (r_cnt == c_LAST_READ);
  assign w_is_word   = (bus.size != c_SIZE_HALF) && (bus.size != c_SIZE_BYTE);

  always_comb begin
    w_misaligned = 1'b0;
    case (bus.size)
      c_SIZE_HALF: w_misaligned = bus.addr[0];
      c_SIZE_BYTE: w_misaligned = 1'b0;
      default:     w_misaligned = (bus.addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_misaligned)   w_state_next = S_ERR;
          else if (w_is_word) w_state_next = S_WRITE;
          else                w_state_next = S_READ;
        end
      end
      S_READ:  if (w_last_read) w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request registers only load on acceptance, so later input churn is harmless
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_size      <= '0;
      r_data      <= '0;
      r_read_word <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.addr;
        r_size <= bus.size;
        r_data <= bus.store_data;
      end
      if (w_last_read) begin
        r_read_word <= bus.mem_data_in;
      end
      if (r_state == S_READ) begin
        r_cnt <= r_cnt + 3'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_merged = r_read_word;
    case (r_size)
      c_SIZE_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
      c_SIZE_HALF: begin
        if (r_addr[1]) w_merged[31:16] = r_data[15:0];
        else           w_merged[15:0]  = r_data[15:0];
      end
      default:     w_merged = r_data;
    endcase
  end

  // Strobes decode straight from the state so a reset kills a write instantly
  assign bus.mem_addr     = {r_addr[31:2], 2'b00};
  assign bus.mem_data_out = w_merged;
  assign bus.mem_wr       = (r_state == S_WRITE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE) || (r_state == S_ERR);
  assign bus.misaligned   = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_store_merge_ctrl.sv
// ============================================================================
// Module  : tb_store_merge_ctrl
// Purpose : Directed bench driving READ_LATENCY=1 and =3 units in parallel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_merge_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  store_merge_if bus1 ();
  store_merge_if bus3 ();

  store_merge_ctrl #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  store_merge_ctrl #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  assign bus1.start = start;       assign bus3.start = start;
  assign bus1.size = size;         assign bus3.size = size;
  assign bus1.addr = addr;         assign bus3.addr = addr;
  assign bus1.store_data = sdata;  assign bus3.store_data = sdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hAABBCCDD : 32'h0;
  endfunction

  // Read data is valid only in the READ_LATENCY-th read cycle; garbage otherwise
  int age1 = 0;
  int age3 = 0;
  logic rd1, rd3;
  assign rd1 = bus1.busy & ~bus1.mem_wr & ~bus1.done;
  assign rd3 = bus3.busy & ~bus3.mem_wr & ~bus3.done;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      age1 <= 0;
      age3 <= 0;
    end else begin
      age1 <= rd1 ? age1 + 1 : 0;
      age3 <= rd3 ? age3 + 1 : 0;
    end
  end
  assign bus1.mem_data_in = (rd1 && age1 == 0) ? mem_word(bus1.mem_addr) : 32'hBAD0BAD0;
  assign bus3.mem_data_in = (rd3 && age3 == 2) ? mem_word(bus3.mem_addr) : 32'hBAD0BAD0;

  logic        mw[2], bz[2], dn[2], ms[2];
  logic [31:0] ma[2], md[2];
  int          lat[2] = '{1, 3};
  assign mw[0] = bus1.mem_wr; assign mw[1] = bus3.mem_wr;
  assign bz[0] = bus1.busy;   assign bz[1] = bus3.busy;
  assign dn[0] = bus1.done;   assign dn[1] = bus3.done;
  assign ms[0] = bus1.misaligned; assign ms[1] = bus3.misaligned;
  assign ma[0] = bus1.mem_addr;     assign ma[1] = bus3.mem_addr;
  assign md[0] = bus1.mem_data_out; assign md[1] = bus3.mem_data_out;

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s rl%0d: observed %h expected %h", tag, lat[d], obs, exp);
    end
  endtask

  // One request on both units; sampled on falling edges, cycle 1 = first after acceptance
  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] dat, input logic is_word, input logic exp_mis,
                       input logic [31:0] exp_addr, input logic [31:0] exp_data, input logic inject);
    int wr_cnt[2], wr_cyc[2], done_cyc[2], exp_done[2], exp_wr[2];
    logic [31:0] wdat[2], wadr[2];
    logic mis[2], busy_ok[2], idle_after[2];
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; wr_cyc[d] = 0; done_cyc[d] = 0; wdat[d] = 'x; wadr[d] = 'x;
      mis[d] = 1'bx; busy_ok[d] = 1'b1; idle_after[d] = 1'b0;
      exp_wr[d]   = is_word ? 1 : lat[d] + 1;
      exp_done[d] = exp_mis ? 1 : exp_wr[d] + 1;
    end
    @(negedge clk);
    size = sz; addr = a; sdata = dat; start = 1'b1;
    @(negedge clk);
    start = 1'b0; size = 2'b10; addr = 32'h200; sdata = 32'h55555555;
    for (int n = 1; n <= 10; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (mw[d]) begin
          wr_cnt[d]++; wr_cyc[d] = n; wdat[d] = md[d]; wadr[d] = ma[d];
        end
        if (dn[d] && done_cyc[d] == 0) begin
          done_cyc[d] = n; mis[d] = ms[d];
        end
        if (n <= exp_done[d] && !bz[d]) busy_ok[d] = 1'b0;
        if (n == exp_done[d] + 1) idle_after[d] = !bz[d];
      end
      if (inject && n == 2) begin
        start = 1'b1; size = 2'b10; addr = 32'h104; sdata = 32'h99999999;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      check({tag, " done_cycle"}, d, done_cyc[d], exp_done[d]);
      check({tag, " misaligned"}, d, 32'(mis[d]), 32'(exp_mis));
      check({tag, " write_count"}, d, wr_cnt[d], exp_mis ? 0 : 1);
      check({tag, " busy_then_idle"}, d, 32'(busy_ok[d] & idle_after[d]), 32'd1);
      if (!exp_mis) begin
        check({tag, " write_cycle"}, d, wr_cyc[d], exp_wr[d]);
        check({tag, " write_addr"}, d, wadr[d], exp_addr);
        check({tag, " write_data"}, d, wdat[d], exp_data);
      end
    end
  endtask

  initial begin
    int stray;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset_flags", d, {28'h0, mw[d], bz[d], dn[d], ms[d]}, 32'h0);
      check("reset_addr", d, ma[d], 32'h0);
      check("reset_wdata", d, md[d], 32'h0);
    end

    store("sb_101", 2'b10, 32'h101, 32'h12345677, 1'b0, 1'b0, 32'h100, 32'hAABB77DD, 1'b1);
    store("sh_102", 2'b01, 32'h102, 32'hFFFFBEEF, 1'b0, 1'b0, 32'h100, 32'hBEEFCCDD, 1'b0);
    store("sh_100", 2'b01, 32'h100, 32'hFFFFBEEF, 1'b0, 1'b0, 32'h100, 32'hAABBBEEF, 1'b1);
    store("sb_103", 2'b10, 32'h103, 32'h000000A5, 1'b0, 1'b0, 32'h100, 32'hA5BBCCDD, 1'b0);
    store("sw_104", 2'b00, 32'h104, 32'hDEADBEEF, 1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 1'b1);
    store("rsv_108", 2'b11, 32'h108, 32'h01020304, 1'b1, 1'b0, 32'h108, 32'h01020304, 1'b0);
    store("sh_103", 2'b01, 32'h103, 32'h00001234, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    store("sw_102", 2'b00, 32'h102, 32'h00001234, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);

    // Reset asserted mid-READ must clear everything without waiting for a clock
    @(negedge clk);
    size = 2'b10; addr = 32'h100; sdata = 32'h00000077; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) check("in_read", d, {30'h0, bz[d], mw[d]}, 32'h2);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("async_flags", d, {28'h0, mw[d], bz[d], dn[d], ms[d]}, 32'h0);
      check("async_addr", d, ma[d], 32'h0);
      check("async_wdata", d, md[d], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (mw[d] || bz[d]) stray++;
    end
    check("post_reset_quiet", 0, stray, 0);

    store("sb_after_rst", 2'b10, 32'h100, 32'h00000011, 1'b0, 1'b0, 32'h100, 32'hAABBCC11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
